// File: rtl/radio_pkg.sv
// Shared constants and state encodings for the radio link controller.
// Holds the frame defaults, the controller state set and the receive-parser phases.
package radio_pkg;

   localparam int unsigned DefMaxLen = 16;
   localparam logic [7:0]  DefSync   = 8'hA5;

   typedef logic [3:0] state_t;

   localparam state_t StIdle     = 4'd0;
   localparam state_t StLoad     = 4'd1;
   localparam state_t StTxIssue  = 4'd2;
   localparam state_t StTxWaitHi = 4'd3;
   localparam state_t StTxWaitLo = 4'd4;
   localparam state_t StRxIssue  = 4'd5;
   localparam state_t StRxWaitHi = 4'd6;
   localparam state_t StRxWaitLo = 4'd7;
   localparam state_t StRxEval   = 4'd8;

   typedef logic [1:0] rx_phase_t;

   localparam rx_phase_t PhHunt    = 2'd0;
   localparam rx_phase_t PhLen     = 2'd1;
   localparam rx_phase_t PhPayload = 2'd2;
   localparam rx_phase_t PhChk     = 2'd3;

endpackage

// File: rtl/radio_frame_buf.sv
// Payload store for one outgoing packet: DEPTH x 8, synchronous write, combinational read.
// Contents are deliberately not reset.
module radio_frame_buf #(
   parameter int unsigned DEPTH = 16
) (
   input  logic       clk,
   input  logic       wr_en,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [7:0] rd_addr,
   output logic [7:0] rd_data
);

   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0]  DepthB = 8'(DEPTH);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr < DepthB)) begin
         mem[wr_addr[AW-1:0]] <= wr_data;
      end
   end

   // Out-of-range reads return zero instead of an undefined entry.
   always_comb begin
      rd_data = 8'h00;
      if (rd_addr < DepthB) begin
         rd_data = mem[rd_addr[AW-1:0]];
      end
   end

endmodule

// File: rtl/radio_link_ctrl.sv
// Half-duplex radio link controller: frames host bytes as SYNC/LEN/payload/CHK for the
// radio, and parses received bytes back into payload pulses with checksum status.
module radio_link_ctrl
   import radio_pkg::*;
#(
   parameter int unsigned MAX_LEN = DefMaxLen,
   parameter logic [7:0]  SYNC    = DefSync
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       tx_done,
   output logic       tx_trunc,
   input  logic       rx_listen,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic       radio_send,
   output logic       radio_receive,
   output logic [7:0] radio_tx_data,
   input  logic       radio_busy,
   input  logic [7:0] radio_rx_data
);

   localparam logic [7:0] MaxIdx = 8'(MAX_LEN - 1);
   localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] len_q, len_d;
   logic [7:0] chk_q, chk_d;
   logic [8:0] idx_q, idx_d;
   logic [7:0] rx_byte_q, rx_byte_d;
   rx_phase_t  rx_phase_q, rx_phase_d;
   logic [7:0] rx_len_q, rx_len_d;
   logic [7:0] rx_cnt_q, rx_cnt_d;
   logic [7:0] rx_xor_q, rx_xor_d;

   logic       load_acc;
   logic [7:0] buf_rd_data;
   logic [7:0] frame_byte;
   logic       last_byte;
   logic       tx_active;

   assign load_acc = (state_q == StLoad) && in_valid;

   radio_frame_buf #(
      .DEPTH(MAX_LEN)
   ) u_frame_buf (
      .clk    (clk),
      .wr_en  (load_acc),
      .wr_addr(cnt_q),
      .wr_data(in_data),
      .rd_addr(idx_q[7:0] - 8'd2),
      .rd_data(buf_rd_data)
   );

   // Frame index 0 is SYNC, 1 is LEN, 2..LEN+1 payload, LEN+2 the check byte.
   always_comb begin
      frame_byte = chk_q ^ len_q;
      if (idx_q == 9'd0) begin
         frame_byte = SYNC;
      end else if (idx_q == 9'd1) begin
         frame_byte = len_q;
      end else if (idx_q <= ({1'b0, len_q} + 9'd1)) begin
         frame_byte = buf_rd_data;
      end
   end

   assign last_byte     = (idx_q == ({1'b0, len_q} + 9'd2));
   assign tx_active     = (state_q == StTxIssue) || (state_q == StTxWaitHi) ||
                          (state_q == StTxWaitLo);
   assign radio_tx_data = tx_active ? frame_byte : 8'h00;
   assign in_ready      = (state_q == StLoad);
   assign out_data      = out_valid ? rx_byte_q : 8'h00;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      chk_d         = chk_q;
      idx_d         = idx_q;
      rx_byte_d     = rx_byte_q;
      rx_phase_d    = rx_phase_q;
      rx_len_d      = rx_len_q;
      rx_cnt_d      = rx_cnt_q;
      rx_xor_d      = rx_xor_q;
      tx_done       = 1'b0;
      tx_trunc      = 1'b0;
      out_valid     = 1'b0;
      out_last      = 1'b0;
      pkt_ok        = 1'b0;
      pkt_err       = 1'b0;
      radio_send    = 1'b0;
      radio_receive = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d      = 8'd0;
            chk_d      = 8'd0;
            idx_d      = 9'd0;
            rx_phase_d = PhHunt;
            if (in_valid) begin
               state_d = StLoad;
            end else if (rx_listen) begin
               state_d = StRxIssue;
            end
         end
         StLoad: begin
            if (in_valid) begin
               cnt_d = cnt_q + 8'd1;
               chk_d = chk_q ^ in_data;
               if (in_last || (cnt_q == MaxIdx)) begin
                  len_d    = cnt_q + 8'd1;
                  tx_trunc = !in_last;
                  state_d  = StTxIssue;
               end
            end
         end
         StTxIssue: begin
            if (!radio_busy) begin
               radio_send = 1'b1;
               state_d    = StTxWaitHi;
            end
         end
         StTxWaitHi: begin
            if (radio_busy) state_d = StTxWaitLo;
         end
         StTxWaitLo: begin
            if (!radio_busy) begin
               if (last_byte) begin
                  tx_done = 1'b1;
                  state_d = StIdle;
               end else begin
                  idx_d   = idx_q + 9'd1;
                  state_d = StTxIssue;
               end
            end
         end
         StRxIssue: begin
            if (!radio_busy) begin
               radio_receive = 1'b1;
               state_d       = StRxWaitHi;
            end
         end
         StRxWaitHi: begin
            if (radio_busy) state_d = StRxWaitLo;
         end
         StRxWaitLo: begin
            if (!radio_busy) begin
               rx_byte_d = radio_rx_data;
               state_d   = StRxEval;
            end
         end
         StRxEval: begin
            unique case (rx_phase_q)
               PhHunt: begin
                  if (rx_byte_q == SYNC) rx_phase_d = PhLen;
               end
               PhLen: begin
                  if ((rx_byte_q == 8'd0) || (rx_byte_q > MaxLenB)) begin
                     pkt_err    = 1'b1;
                     rx_phase_d = PhHunt;
                  end else begin
                     rx_len_d   = rx_byte_q;
                     rx_cnt_d   = 8'd0;
                     rx_xor_d   = 8'd0;
                     rx_phase_d = PhPayload;
                  end
               end
               PhPayload: begin
                  // Received check byte covers the payload bytes only.
                  out_valid = 1'b1;
                  rx_xor_d  = rx_xor_q ^ rx_byte_q;
                  rx_cnt_d  = rx_cnt_q + 8'd1;
                  if (rx_cnt_q == (rx_len_q - 8'd1)) begin
                     out_last   = 1'b1;
                     rx_phase_d = PhChk;
                  end
               end
               PhChk: begin
                  pkt_ok     = (rx_byte_q == rx_xor_q);
                  pkt_err    = (rx_byte_q != rx_xor_q);
                  rx_phase_d = PhHunt;
               end
               default: rx_phase_d = PhHunt;
            endcase
            if (rx_listen) begin
               state_d = StRxIssue;
            end else begin
               state_d    = StIdle;
               rx_phase_d = PhHunt;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= 8'd0;
         len_q      <= 8'd0;
         chk_q      <= 8'd0;
         idx_q      <= 9'd0;
         rx_byte_q  <= 8'd0;
         rx_phase_q <= PhHunt;
         rx_len_q   <= 8'd0;
         rx_cnt_q   <= 8'd0;
         rx_xor_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         chk_q      <= chk_d;
         idx_q      <= idx_d;
         rx_byte_q  <= rx_byte_d;
         rx_phase_q <= rx_phase_d;
         rx_len_q   <= rx_len_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_xor_q   <= rx_xor_d;
      end
   end

endmodule

// File: tb/tb_radio_link_ctrl.sv
// Directed bench for radio_link_ctrl with a behavioural radio (8-cycle busy) and
// hand-computed frames and receive results.
module tb_radio_link_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       tx_done, tx_trunc;
   logic       rx_listen = 1'b0;
   logic       out_valid, out_last, pkt_ok, pkt_err;
   logic [7:0] out_data;
   logic       radio_send, radio_receive;
   logic [7:0] radio_tx_data;
   logic       radio_busy = 1'b0;
   logic [7:0] radio_rx_data = 8'h00;

   always #5 clk = ~clk;

   radio_link_ctrl u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .tx_done      (tx_done),
      .tx_trunc     (tx_trunc),
      .rx_listen    (rx_listen),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .pkt_ok       (pkt_ok),
      .pkt_err      (pkt_err),
      .radio_send   (radio_send),
      .radio_receive(radio_receive),
      .radio_tx_data(radio_tx_data),
      .radio_busy   (radio_busy),
      .radio_rx_data(radio_rx_data)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Radio model: busy high for 8 cycles starting the cycle after a request.
   logic [7:0] rx_q[$];
   logic [7:0] sent_q[$];
   int         send_cnt = 0, recv_cnt = 0, first_send = -1;
   logic       rx_req;
   always begin
      @(negedge clk);
      if (!rst && (radio_send || radio_receive)) begin
         rx_req = radio_receive;
         if (radio_send) begin
            sent_q.push_back(radio_tx_data);
            if (first_send < 0) first_send = cyc;
            send_cnt++;
         end else begin
            recv_cnt++;
         end
         @(posedge clk);
         #1 radio_busy = 1'b1;
         repeat (8) @(posedge clk);
         #1 radio_busy = 1'b0;
         if (rx_req) radio_rx_data = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      end
   end

   int         done_cnt = 0, done_cyc = 0, trunc_cnt = 0, ok_cnt = 0, err_cnt = 0;
   logic [7:0] out_q[$];
   logic       last_q[$];
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (tx_trunc) trunc_cnt++;
         if (out_valid) begin
            out_q.push_back(out_data);
            last_q.push_back(out_last);
         end
         if (pkt_ok) ok_cnt++;
         if (pkt_err) err_cnt++;
      end
   end

   task automatic clear_obs();
      sent_q.delete();
      out_q.delete();
      last_q.delete();
      send_cnt = 0; recv_cnt = 0; first_send = -1;
      done_cnt = 0; trunc_cnt = 0; ok_cnt = 0; err_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1; in_data = d; in_last = last;
      @(negedge clk);
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("host_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 1000 && done_cnt < target; i++) @(negedge clk);
      check_eq("tx_done_count", 32'(done_cnt), 32'(target));
   endtask

   logic [7:0] exp_q[$];
   task automatic check_frame(input string tag);
      check_eq({tag, "_len"}, 32'(sent_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         check_eq($sformatf("%s_b%0d", tag, i),
                  (i < sent_q.size()) ? 32'(sent_q[i]) : 32'hDEAD, 32'(exp_q[i]));
      end
   endtask

   task automatic rx_run(input int exp_outs, input int exp_ok, input int exp_err, input string tag);
      @(posedge clk);
      #1 rx_listen = 1'b1;
      for (int i = 0; i < 600 && (ok_cnt + err_cnt) == 0; i++) @(negedge clk);
      rx_listen = 1'b0;
      repeat (30) @(negedge clk);
      check_eq({tag, "_nout"}, 32'(out_q.size()), 32'(exp_outs));
      check_eq({tag, "_ok"}, 32'(ok_cnt), 32'(exp_ok));
      check_eq({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
   endtask

   logic [7:0] x;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_outputs",
               {8'h00, in_ready, tx_done, tx_trunc, out_valid, out_data, out_last, pkt_ok,
                pkt_err, radio_send, radio_receive, radio_tx_data}, 32'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("idle_in_ready", 32'(in_ready), 32'd0);
      check_eq("idle_no_send", 32'(send_cnt + recv_cnt), 32'd0);

      // Three-byte packet
      @(posedge clk);
      #1 clear_obs();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b1);
      wait_done(1);
      repeat (3) @(negedge clk);
      exp_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      check_frame("pkt3");
      check_eq("pkt3_cycles", 32'(done_cyc - first_send + 1), 32'd60);
      check_eq("pkt3_done_once", 32'(done_cnt), 32'd1);
      check_eq("pkt3_no_trunc", 32'(trunc_cnt), 32'd0);

      // Twenty bytes: truncation at 16, bytes 17-20 form the next packet
      clear_obs();
      for (int i = 1; i <= 20; i++) send_byte(8'(8'h20 + i), (i == 20));
      wait_done(2);
      repeat (3) @(negedge clk);
      exp_q = '{8'hA5, 8'h10};
      x = 8'h10;
      for (int i = 1; i <= 16; i++) begin
         exp_q.push_back(8'(8'h20 + i));
         x = x ^ 8'(8'h20 + i);
      end
      exp_q.push_back(x);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h04);
      x = 8'h04;
      for (int i = 17; i <= 20; i++) begin
         exp_q.push_back(8'(8'h20 + i));
         x = x ^ 8'(8'h20 + i);
      end
      exp_q.push_back(x);
      check_frame("trunc");
      check_eq("trunc_once", 32'(trunc_cnt), 32'd1);

      // Host and listen arrive together: transmit wins
      clear_obs();
      @(posedge clk);
      #1 rx_listen = 1'b1;
      send_byte(8'h77, 1'b1);
      for (int i = 0; i < 300 && done_cnt < 1; i++) @(negedge clk);
      rx_listen = 1'b0;
      check_eq("tie_no_receive", 32'(recv_cnt), 32'd0);
      repeat (20) @(negedge clk);
      exp_q = '{8'hA5, 8'h01, 8'h77, 8'h76};
      check_frame("tie");
      check_eq("tie_still_no_receive", 32'(recv_cnt), 32'd0);

      // Good received frame after one noise byte
      clear_obs();
      rx_q = '{8'h00, 8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h99};
      rx_run(2, 1, 0, "rx_good");
      check_eq("rx_good_b0", 32'(out_q[0]), 32'h5A);
      check_eq("rx_good_l0", 32'(last_q[0]), 32'd0);
      check_eq("rx_good_b1", 32'(out_q[1]), 32'hC3);
      check_eq("rx_good_l1", 32'(last_q[1]), 32'd1);

      // Bad check byte
      clear_obs();
      rx_q = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h98};
      rx_run(2, 0, 1, "rx_badchk");
      check_eq("rx_badchk_b1", 32'(out_q[1]), 32'hC3);

      // LEN boundaries: zero and MAX_LEN+1
      clear_obs();
      rx_q = '{8'hA5, 8'h00};
      rx_run(0, 0, 1, "rx_len0");
      clear_obs();
      rx_q = '{8'hA5, 8'h11};
      rx_run(0, 0, 1, "rx_len17");

      // Reset in the wait-low phase of the first payload byte
      clear_obs();
      @(posedge clk);
      #1;
      in_valid = 1'b1; in_data = 8'h3C; in_last = 1'b0;
      send_byte(8'h3C, 1'b0);
      send_byte(8'h4D, 1'b1);
      for (int i = 0; i < 300 && !(radio_send && radio_tx_data == 8'h3C); i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check_eq("mid_tx_data", 32'(radio_tx_data), 32'h3C);
      #1 rst = 1'b1;
      #1;
      check_eq("mid_rst_outputs",
               {8'h00, in_ready, tx_done, tx_trunc, out_valid, out_data, out_last, pkt_ok,
                pkt_err, radio_send, radio_receive, radio_tx_data}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_obs();
      send_byte(8'h5C, 1'b1);
      wait_done(1);
      repeat (3) @(negedge clk);
      exp_q = '{8'hA5, 8'h01, 8'h5C, 8'h5D};
      check_frame("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
